multicycle_alu: RTL and testbench
=================================

Name: multicycle_alu

Overview:
- Parametrised, registered successor to the datapath's combinational ALU.
- Single-cycle logic/compare/shift ops complete in 1 cycle.
- Multiply and divide run iteratively over DATA_WIDTH cycles and return the full double-width result in HI/LO.
- Sits in the EX stage. Uses a start/busy/done handshake so control can stall the pipeline on long ops.

Parameters:
- CONTROL_WIDTH, 4: width of the ALUCtrl opcode.
- DATA_WIDTH, 32: operand and result width. Must be ≥2.

Ports:
- clk, input, 1: single clock, rising-edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: accept A/B/ALUCtrl/Shamt this cycle. Honoured only when busy=0.
- ALUCtrl, input, CONTROL_WIDTH: opcode.
- Shamt, input, 5: shift amount.
- A, input, DATA_WIDTH: operand A (unsigned).
- B, input, DATA_WIDTH: operand B (unsigned).
- busy, output, 1: op in progress. start is ignored while high.
- done, output, 1: one-cycle pulse when results are valid.
- ALU_result, output, DATA_WIDTH: primary result, registered.
- Zero, output, 1: high when ALU_result==0, registered alongside ALU_result.
- HI, output, DATA_WIDTH: mult upper product or div remainder. Otherwise 0.
- LO, output, DATA_WIDTH: mult lower product or div quotient. Otherwise equals ALU_result.
- div_by_zero, output, 1: sticky for the result. Set on div with B==0.

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE; busy=0; done=0.
  - ALU_result=0; Zero=1; HI=0; LO=0; div_by_zero=0.
  - Iteration counter and working registers cleared.
- Opcodes:
  - 0 and; 1 or; 2 add; 3 sub (both mod 2^DATA_WIDTH).
  - 4 A<B; 5 A>B (1/0).
  - 6 ~A.
  - 7 mult; 8 div.
  - 9 A<<Shamt; 10 A>>Shamt (logical).
  - 11 A<=B; 12 A>=B; 13 A==B; 14 A!=B (1/0).
  - 15: see Optional Feature.
  - Unsupported opcode: result 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start=1 with a single-cycle op:
  - Compute and register result at the same edge; go to DONE.
  - done=1 in cycle t+1 (start sampled at edge t).
- IDLE, start=1 with op 7:
  - Load multiplicand/multiplier, clear the 2*DATA_WIDTH accumulator, counter=DATA_WIDTH; go to MUL; busy=1 from t+1.
  - Each MUL cycle does one shift-add step and decrements the counter. At counter==1 the final step lands and the FSM goes to DONE.
  - done at cycle t+DATA_WIDTH+1.
  - {HI,LO} = A*B exactly (no truncation). ALU_result = LO.
- IDLE, start=1 with op 8:
  - Restoring division, one quotient bit per cycle, same timing as MUL.
  - LO = A/B, HI = A%B, ALU_result = LO.
  - B==0: do not iterate. Go straight to DONE next cycle with LO=all-ones, HI=A, ALU_result=all-ones, div_by_zero=1.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
  - start asserted in DONE is accepted (back-to-back). The new op's first cycle follows directly.
- Output hold: results and div_by_zero hold until the next accepted start, which clears div_by_zero.
- start while busy=1: ignored, no side effects. Inputs are only sampled at acceptance, so they may change during MUL/DIV.
- rst mid-operation: abort immediately to reset values. No done pulse.
- Zero is computed from the registered ALU_result; for mult it reflects LO only.
- Shamt ≥ DATA_WIDTH yields 0 for shifts.

Optional Feature:
- Macro: MULTICYCLE_ALU_SRA_EN.
- Defined: opcode 15 = arithmetic right shift of A by Shamt (sign bit replicated), single-cycle.
- Undefined: opcode 15 yields ALU_result=0, single-cycle. Logic removed.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (ALU_AND … ALU_SRA);
  - the state enum (IDLE/MUL/DIV/DONE);
  - the default DATA_WIDTH.
- One natural sub-module, alu_iter_muldiv: the shared iterative shift engine for MUL/DIV with load/step/finish handshake.
- The top keeps the FSM, single-cycle datapath and output registers.

Test Plan:
- Reset: assert rst mid-MUL (cycle 10) -> busy=0, done never pulses, ALU_result=0, Zero=1, HI=LO=0.
- Add wrap: A=32'hFFFFFFFF, B=1, op 2 -> done at t+1, ALU_result=0, Zero=1. Op 13 with A=B=5 -> ALU_result=1.
- Multiply: A=32'hFFFFFFFF, B=32'h2, op 7 -> busy 32 cycles, done at t+33, HI=1, LO=32'hFFFFFFFE.
- Divide: A=100, B=7, op 8 -> done at t+33, LO=14, HI=2, div_by_zero=0.
- Divide by zero: A=9, B=0 -> done at t+2, LO=32'hFFFFFFFF, HI=9, div_by_zero=1. Next start clears the flag.
- Handshake: start held high during DIV with op 2 -> ignored. Start in DONE cycle accepted. SRA (macro defined) A=32'h80000000, Shamt=4 -> 32'hF8000000; macro undefined -> 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and default width for the multicycle ALU.
package alu_pkg;

  localparam int unsigned ALU_DATA_WIDTH = 32;

  localparam int unsigned ALU_AND  = 0;
  localparam int unsigned ALU_OR   = 1;
  localparam int unsigned ALU_ADD  = 2;
  localparam int unsigned ALU_SUB  = 3;
  localparam int unsigned ALU_LT   = 4;
  localparam int unsigned ALU_GT   = 5;
  localparam int unsigned ALU_NOT  = 6;
  localparam int unsigned ALU_MULT = 7;
  localparam int unsigned ALU_DIV  = 8;
  localparam int unsigned ALU_SLL  = 9;
  localparam int unsigned ALU_SRL  = 10;
  localparam int unsigned ALU_LE   = 11;
  localparam int unsigned ALU_GE   = 12;
  localparam int unsigned ALU_EQ   = 13;
  localparam int unsigned ALU_NE   = 14;
  localparam int unsigned ALU_SRA  = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift engine: shift-add multiply or restoring divide, one bit per step.
// hi/lo hold {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  step,
  output logic                  last_c,
  output logic [DATA_WIDTH-1:0] hi_c,
  output logic [DATA_WIDTH-1:0] lo_c
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic                  div_q, div_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [DATA_WIDTH:0]   mul_sum, div_shift;
  logic [DATA_WIDTH-1:0] div_diff;
  logic                  div_ge;

  // Result of one step from the current working registers.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[DATA_WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // Remainder stays below the divisor, so the low bits of the difference are exact.
    div_diff  = div_shift[DATA_WIDTH-1:0] - opnd_q;
    if (div_q) begin
      hi_c = div_ge ? div_diff : div_shift[DATA_WIDTH-1:0];
      lo_c = {lo_q[DATA_WIDTH-2:0], div_ge};
    end else begin
      hi_c = mul_sum[DATA_WIDTH:1];
      lo_c = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
    end
    last_c = (cnt_q == CNT_W'(1));
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    if (load) begin
      hi_d   = '0;
      lo_d   = is_div ? a : b;
      opnd_d = is_div ? b : a;
      div_d  = is_div;
      cnt_d  = CNT_W'(DATA_WIDTH);
    end else if (step) begin
      hi_d  = hi_c;
      lo_d  = lo_c;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Registered EX-stage ALU: single-cycle ops plus iterative mult/div with start/busy/done.
// Opcode 15 is an arithmetic right shift when MULTICYCLE_ALU_SRA_EN is defined, else 0.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned CONTROL_WIDTH = 4,
  parameter int unsigned DATA_WIDTH    = ALU_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CONTROL_WIDTH-1:0] ALUCtrl,
  input  logic [4:0]               Shamt,
  input  logic [DATA_WIDTH-1:0]    A,
  input  logic [DATA_WIDTH-1:0]    B,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    ALU_result,
  output logic                     Zero,
  output logic [DATA_WIDTH-1:0]    HI,
  output logic [DATA_WIDTH-1:0]    LO,
  output logic                     div_by_zero
);

  alu_state_e            state_q, state_d;
  logic                  busy_q, busy_d, done_q, done_d, zero_q, zero_d;
  logic                  dbz_q, dbz_d, dbz_pend_q, dbz_pend_d;
  logic [DATA_WIDTH-1:0] res_q, res_d, hi_q, hi_d, lo_q, lo_d, dbz_a_q, dbz_a_d;

  logic [31:0]           op_c;
  logic                  shift_ovf_c;
  logic [DATA_WIDTH-1:0] single_res_c;
  logic                  eng_load, eng_div, eng_step, eng_last_c;
  logic [DATA_WIDTH-1:0] eng_hi_c, eng_lo_c;

  alu_iter_muldiv #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .load   (eng_load),
    .is_div (eng_div),
    .a      (A),
    .b      (B),
    .step   (eng_step),
    .last_c (eng_last_c),
    .hi_c   (eng_hi_c),
    .lo_c   (eng_lo_c)
  );

  // Single-cycle datapath; mult/div and unknown opcodes fall to 0 here.
  always_comb begin
    op_c         = 32'(ALUCtrl);
    shift_ovf_c  = (32'(Shamt) >= DATA_WIDTH);
    single_res_c = '0;
    case (op_c)
      ALU_AND: single_res_c = A & B;
      ALU_OR:  single_res_c = A | B;
      ALU_ADD: single_res_c = A + B;
      ALU_SUB: single_res_c = A - B;
      ALU_LT:  single_res_c = DATA_WIDTH'(A < B);
      ALU_GT:  single_res_c = DATA_WIDTH'(A > B);
      ALU_NOT: single_res_c = ~A;
      ALU_SLL: single_res_c = shift_ovf_c ? '0 : (A << Shamt);
      ALU_SRL: single_res_c = shift_ovf_c ? '0 : (A >> Shamt);
      ALU_LE:  single_res_c = DATA_WIDTH'(A <= B);
      ALU_GE:  single_res_c = DATA_WIDTH'(A >= B);
      ALU_EQ:  single_res_c = DATA_WIDTH'(A == B);
      ALU_NE:  single_res_c = DATA_WIDTH'(A != B);
`ifdef MULTICYCLE_ALU_SRA_EN
      ALU_SRA: single_res_c = shift_ovf_c ? '0 : DATA_WIDTH'($signed(A) >>> Shamt);
`endif
      default: single_res_c = '0;
    endcase
  end

  // FSM next-state and output-register updates.
  always_comb begin
    state_d    = state_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    res_d      = res_q;
    zero_d     = zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dbz_d      = dbz_q;
    dbz_pend_d = dbz_pend_q;
    dbz_a_d    = dbz_a_q;
    eng_load   = 1'b0;
    eng_div    = 1'b0;
    eng_step   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          dbz_d = 1'b0;
          if (op_c == ALU_MULT) begin
            eng_load = 1'b1;
            busy_d   = 1'b1;
            state_d  = MUL;
          end else if (op_c == ALU_DIV) begin
            eng_div    = 1'b1;
            eng_load   = (B != '0);
            dbz_pend_d = (B == '0);
            dbz_a_d    = A;
            busy_d     = 1'b1;
            state_d    = DIV;
          end else begin
            res_d   = single_res_c;
            zero_d  = (single_res_c == '0);
            hi_d    = '0;
            lo_d    = single_res_c;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      MUL, DIV: begin
        busy_d = 1'b1;
        if (dbz_pend_q) begin
          // Divide by zero skips iteration: quotient saturates, remainder is the dividend.
          dbz_pend_d = 1'b0;
          res_d      = '1;
          zero_d     = 1'b0;
          hi_d       = dbz_a_q;
          lo_d       = '1;
          dbz_d      = 1'b1;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = DONE;
        end else begin
          eng_step = 1'b1;
          if (eng_last_c) begin
            res_d   = eng_lo_c;
            zero_d  = (eng_lo_c == '0);
            hi_d    = eng_hi_c;
            lo_d    = eng_lo_c;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_q      <= '0;
      zero_q     <= 1'b1;
      hi_q       <= '0;
      lo_q       <= '0;
      dbz_q      <= 1'b0;
      dbz_pend_q <= 1'b0;
      dbz_a_q    <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      dbz_q      <= dbz_d;
      dbz_pend_q <= dbz_pend_d;
      dbz_a_q    <= dbz_a_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ALU_result  = res_q;
  assign Zero        = zero_q;
  assign HI          = hi_q;
  assign LO          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: arithmetic reference model checked every cycle plus directed literal checks.
module tb_multicycle_alu;

  localparam int unsigned W = 32;

`ifdef MULTICYCLE_ALU_SRA_EN
  localparam logic [31:0] SRA_EXP = 32'hF800_0000;
`else
  localparam logic [31:0] SRA_EXP = 32'h0000_0000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    ALUCtrl = '0;
  logic [4:0]    Shamt = '0;
  logic [W-1:0]  A = '0, B = '0;
  logic          busy, done, Zero, div_by_zero;
  logic [W-1:0]  ALU_result, HI, LO;

  int checks = 0;
  int errors = 0;

  multicycle_alu #(.CONTROL_WIDTH(4), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUCtrl(ALUCtrl), .Shamt(Shamt),
    .A(A), .B(B), .busy(busy), .done(done), .ALU_result(ALU_result),
    .Zero(Zero), .HI(HI), .LO(LO), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: what one accepted operation must produce and how many busy cycles it takes.
  typedef struct packed {
    int unsigned cyc;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } gold_t;

  function automatic gold_t golden(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
    gold_t g;
    logic [63:0] prod;
    g = '0;
    case (op)
      4'd0:  g.res = a & b;
      4'd1:  g.res = a | b;
      4'd2:  g.res = a + b;
      4'd3:  g.res = a - b;
      4'd4:  g.res = (a < b) ? 32'd1 : 32'd0;
      4'd5:  g.res = (a > b) ? 32'd1 : 32'd0;
      4'd6:  g.res = ~a;
      4'd9:  g.res = a << sh;
      4'd10: g.res = a >> sh;
      4'd11: g.res = (a <= b) ? 32'd1 : 32'd0;
      4'd12: g.res = (a >= b) ? 32'd1 : 32'd0;
      4'd13: g.res = (a == b) ? 32'd1 : 32'd0;
      4'd14: g.res = (a != b) ? 32'd1 : 32'd0;
`ifdef MULTICYCLE_ALU_SRA_EN
      4'd15: g.res = 32'($signed(a) >>> sh);
`else
      4'd15: g.res = 32'd0;
`endif
      default: g.res = 32'd0;
    endcase
    g.lo = g.res;
    if (op == 4'd7) begin
      prod  = 64'(a) * 64'(b);
      g.hi  = prod[63:32];
      g.lo  = prod[31:0];
      g.res = g.lo;
      g.cyc = W;
    end else if (op == 4'd8) begin
      if (b == 32'd0) begin
        g.hi = a; g.lo = 32'hFFFF_FFFF; g.res = g.lo; g.dbz = 1'b1; g.cyc = 1;
      end else begin
        g.hi = a % b; g.lo = a / b; g.res = g.lo; g.cyc = W;
      end
    end
    return g;
  endfunction

  gold_t g_c, pend;
  always_comb g_c = golden(ALUCtrl, A, B, Shamt);

  logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [31:0] m_res = '0, m_hi = '0, m_lo = '0;
  int unsigned m_rem = 0;

  // Transaction-level model: accept when idle, count down busy cycles, then publish.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_rem <= 0;
      m_res <= '0; m_hi <= '0; m_lo <= '0; m_dbz <= 1'b0; pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_rem == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
          m_res <= pend.res; m_hi <= pend.hi; m_lo <= pend.lo; m_dbz <= pend.dbz;
        end else begin
          m_rem <= m_rem - 1;
        end
      end else if (start) begin
        m_dbz <= 1'b0;
        if (g_c.cyc == 0) begin
          m_done <= 1'b1;
          m_res <= g_c.res; m_hi <= g_c.hi; m_lo <= g_c.lo;
        end else begin
          m_busy <= 1'b1; m_rem <= g_c.cyc; pend <= g_c;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("result", ALU_result, m_res);
    chk("zero", 32'(Zero), 32'(m_res == 32'd0));
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
    chk("dbz", 32'(div_by_zero), 32'(m_dbz));
  end

  // Issue one op at a negedge and wait (bounded) for done; checks latency and literal results.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input int lat,
                        input logic [31:0] e_res, input logic [31:0] e_hi,
                        input logic [31:0] e_lo, input logic e_dbz);
    int n;
    ALUCtrl = op; A = a; B = b; Shamt = sh; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(lat));
    chk({nm, "_res"}, ALU_result, e_res);
    chk({nm, "_hi"}, HI, e_hi);
    chk({nm, "_lo"}, LO, e_lo);
    chk({nm, "_dbz"}, 32'(div_by_zero), 32'(e_dbz));
  endtask

  initial begin
    int n;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_zero", 32'(Zero), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'd1, 5'd0, 1, 32'd0, 32'd0, 32'd0, 1'b0);
    chk("add_wrap_zero", 32'(Zero), 32'd1);
    run_op("eq", 4'd13, 32'd5, 32'd5, 5'd0, 1, 32'd1, 32'd0, 32'd1, 1'b0);
    run_op("sub", 4'd3, 32'd3, 32'd5, 5'd0, 1, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFE, 1'b0);
    run_op("and", 4'd0, 32'hF0F0, 32'hFF00, 5'd0, 1, 32'hF000, 32'd0, 32'hF000, 1'b0);
    run_op("or", 4'd1, 32'hF0F0, 32'h0F00, 5'd0, 1, 32'hFFF0, 32'd0, 32'hFFF0, 1'b0);
    run_op("lt", 4'd4, 32'd3, 32'd5, 5'd0, 1, 32'd1, 32'd0, 32'd1, 1'b0);
    run_op("gt", 4'd5, 32'd3, 32'd5, 5'd0, 1, 32'd0, 32'd0, 32'd0, 1'b0);
    run_op("not", 4'd6, 32'd0, 32'd0, 5'd0, 1, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op("sll", 4'd9, 32'd1, 32'd0, 5'd31, 1, 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b0);
    run_op("srl", 4'd10, 32'h8000_0000, 32'd0, 5'd31, 1, 32'd1, 32'd0, 32'd1, 1'b0);
    run_op("le", 4'd11, 32'd5, 32'd5, 5'd0, 1, 32'd1, 32'd0, 32'd1, 1'b0);
    run_op("ge", 4'd12, 32'd4, 32'd5, 5'd0, 1, 32'd0, 32'd0, 32'd0, 1'b0);
    run_op("ne", 4'd14, 32'd4, 32'd5, 5'd0, 1, 32'd1, 32'd0, 32'd1, 1'b0);
    run_op("sra", 4'd15, 32'h8000_0000, 32'd0, 5'd4, 1, SRA_EXP, 32'd0, SRA_EXP, 1'b0);

    run_op("mul", 4'd7, 32'hFFFF_FFFF, 32'd2, 5'd0, 33, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFE, 1'b0);
    run_op("mul_max", 4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 33, 32'd1, 32'hFFFF_FFFE, 32'd1, 1'b0);
    run_op("div", 4'd8, 32'd100, 32'd7, 5'd0, 33, 32'd14, 32'd2, 32'd14, 1'b0);
    run_op("div_small", 4'd8, 32'd5, 32'd7, 5'd0, 33, 32'd0, 32'd5, 32'd0, 1'b0);
    chk("div_small_zero", 32'(Zero), 32'd1);
    run_op("dbz", 4'd8, 32'd9, 32'd0, 5'd0, 2, 32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFFF, 1'b1);
    run_op("dbz_clear", 4'd2, 32'd1, 32'd2, 5'd0, 1, 32'd3, 32'd0, 32'd3, 1'b0);

    // start held through a divide is ignored, then taken again in the DONE cycle.
    ALUCtrl = 4'd8; A = 32'd100; B = 32'd7; start = 1'b1;
    @(negedge clk);
    ALUCtrl = 4'd2; A = 32'd3; B = 32'd4;
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_latency", 32'(n), 32'd33);
    chk("hold_div_res", ALU_result, 32'd14);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_res", ALU_result, 32'd7);
    chk("b2b_hi", HI, 32'd0);
    @(negedge clk);
    chk("b2b_idle", 32'(done), 32'd0);

    // Reset in the middle of a multiply.
    ALUCtrl = 4'd7; A = 32'd123; B = 32'd456; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_res", ALU_result, 32'd0);
    chk("abort_zero", 32'(Zero), 32'd1);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
